// File: rtl/uart_tx_param_pkg.sv
// Shared UART definitions: parity and FSM encodings, data-width limits.
package uart_tx_param_pkg;

  localparam int unsigned DATA_BITS_MIN = 5;
  localparam int unsigned DATA_BITS_MAX = 9;
  // Wide enough to index up to DATA_BITS_MAX data bits.
  localparam int unsigned BIT_IDX_W     = 4;

  // 2'b11 has no member on purpose: it decodes as "no parity".
  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  function automatic bit data_bits_ok(input int unsigned n);
    return (n >= DATA_BITS_MIN) && (n <= DATA_BITS_MAX);
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Producer-side handshake for the UART transmitter: word plus per-word config.
interface uart_tx_param_if #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DIV_W     = 16
);
  logic                 i_valid;
  logic                 o_ready;
  logic [DATA_BITS-1:0] i_data;
  logic [1:0]           i_parity;
  logic                 i_two_stop;
  logic [DIV_W-1:0]     i_clk_per_bit;

  modport master (
    output i_valid, i_data, i_parity, i_two_stop, i_clk_per_bit,
    input  o_ready
  );

  modport slave (
    input  i_valid, i_data, i_parity, i_two_stop, i_clk_per_bit,
    output o_ready
  );
endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: latches a divisor (0 treated as 1), counts 0..div-1 and
// strobes bit_end on the last cycle of each bit period.
module uart_baud_cnt #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             bit_end
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;

  assign bit_end = run && (cnt == div_q - DIV_W'(1));

  // Divisor capture on load; otherwise free-running wrap while a frame is active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= DIV_W'(1);
      cnt   <= '0;
    end else if (load) begin
      div_q <= (div == '0) ? DIV_W'(1) : div;
      cnt   <= '0;
    end else if (run) begin
      cnt <= bit_end ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with a one-word holding register so frames
// can be sent back-to-back with no idle gap.
module uart_tx_param
  import uart_tx_param_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DIV_W     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_param_if.slave in_if,
  output logic          o_tx,
  output logic          o_busy,
  output logic          o_done
);

  if (!data_bits_ok(DATA_BITS)) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be within 5..9");
  end

  localparam logic [BIT_IDX_W-1:0] LAST_DATA = BIT_IDX_W'(DATA_BITS - 1);

  state_e                 state, state_next;
  logic                   hold_full, hold_par_en, hold_par_odd, hold_two;
  logic [DATA_BITS-1:0]   hold_data, shift;
  logic [DIV_W-1:0]       hold_div;
  logic                   frame_par_en, frame_two, par_bit;
  logic [BIT_IDX_W-1:0]   bit_idx;
  logic                   accept, load, shift_en, bit_inc, bit_clr, bit_end, run;

  assign accept        = in_if.i_valid && !hold_full;
  assign in_if.o_ready = !hold_full;
  assign run           = (state != S_IDLE);
  assign o_busy        = run;

  uart_baud_cnt #(.DIV_W(DIV_W)) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .run     (run),
    .div     (hold_div),
    .bit_end (bit_end)
  );

  // Holding register: filled on accept, emptied when the shifter loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full    <= 1'b0;
      hold_data    <= '0;
      hold_par_en  <= 1'b0;
      hold_par_odd <= 1'b0;
      hold_two     <= 1'b0;
      hold_div     <= '0;
    end else if (accept) begin
      hold_full    <= 1'b1;
      hold_data    <= in_if.i_data;
      hold_par_en  <= (in_if.i_parity == PAR_EVEN) || (in_if.i_parity == PAR_ODD);
      hold_par_odd <= (in_if.i_parity == PAR_ODD);
      hold_two     <= in_if.i_two_stop;
      hold_div     <= in_if.i_clk_per_bit;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  // Shifter and per-frame config; parity bit is precomputed at load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift        <= '0;
      par_bit      <= 1'b0;
      frame_par_en <= 1'b0;
      frame_two    <= 1'b0;
      bit_idx      <= '0;
    end else begin
      if (load) begin
        shift        <= hold_data;
        par_bit      <= (^hold_data) ^ hold_par_odd;
        frame_par_en <= hold_par_en;
        frame_two    <= hold_two;
      end else if (shift_en) begin
        shift <= shift >> 1;
      end
      if (load || bit_clr) begin
        bit_idx <= '0;
      end else if (bit_inc) begin
        bit_idx <= bit_idx + BIT_IDX_W'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state, line level and control strobes.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift_en   = 1'b0;
    bit_inc    = 1'b0;
    bit_clr    = 1'b0;
    o_done     = 1'b0;
    o_tx       = 1'b1;
    case (state)
      S_IDLE: begin
        if (hold_full) begin
          state_next = S_START;
          load       = 1'b1;
        end
      end
      S_START: begin
        o_tx = 1'b0;
        if (bit_end) state_next = S_DATA;
      end
      S_DATA: begin
        o_tx = shift[0];
        if (bit_end) begin
          shift_en = 1'b1;
          if (bit_idx == LAST_DATA) begin
            bit_clr    = 1'b1;
            state_next = frame_par_en ? S_PARITY : S_STOP;
          end else begin
            bit_inc = 1'b1;
          end
        end
      end
      S_PARITY: begin
        o_tx = par_bit;
        if (bit_end) state_next = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_idx == {{(BIT_IDX_W-1){1'b0}}, frame_two}) begin
            o_done = 1'b1;
            // A held word goes straight into its start bit: no idle cycle.
            if (hold_full) begin
              state_next = S_START;
              load       = 1'b1;
            end else begin
              state_next = S_IDLE;
            end
          end else begin
            bit_inc = 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule
